// File: rtl/fm_pkg.sv
// Shared types and constants for the FM sector parser: state encoding, CRC
// parameters, data-mark search window and the sector length helper.
package fm_pkg;

   typedef enum logic [1:0] {
      HUNT       = 2'd0,
      ID_FIELD   = 2'd1,
      WAIT_DAM   = 2'd2,
      DATA_FIELD = 2'd3
   } fm_state_e;

   localparam logic [15:0] CRC_PRESET = 16'hFFFF;
   localparam logic [15:0] CRC_POLY   = 16'h1021;
   localparam int          DAM_WINDOW = 30;
   localparam logic [10:0] ID_LAST    = 11'd5;

   // Payload length for a 2-bit size code: 128, 256, 512 or 1024 bytes.
   function automatic logic [10:0] sector_len(input logic [1:0] size);
      return 11'd128 << size;
   endfunction

endpackage

// File: rtl/fm_sector_parser_if.sv
// Decoded FM byte stream: byte plus strobe and the address-mark flags that
// arrive coincident with it.
interface fm_sector_parser_if;
   logic [7:0] byte_in;
   logic       byte_ready;
   logic       id_am;
   logic       data_am;
   logic       deleted_am;

   modport master (output byte_in, byte_ready, id_am, data_am, deleted_am);
   modport slave  (input  byte_in, byte_ready, id_am, data_am, deleted_am);
endinterface

// File: rtl/crc16_ccitt_byte.sv
// Byte-wide CRC-16-CCITT (MSB first) with a registered accumulator.
// crc_calc is the next value for the current byte, seen from the preset if preset is high.
module crc16_ccitt_byte
   import fm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        preset,
   input  logic        update,
   input  logic [7:0]  data,
   output logic [15:0] crc_calc
);

   logic [15:0] crc_q, crc_d;
   logic [15:0] mix;

   always_comb begin
      mix = (preset ? CRC_PRESET : crc_q) ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         mix = mix[15] ? ((mix << 1) ^ CRC_POLY) : (mix << 1);
      end
   end

   assign crc_calc = mix;

   always_comb begin
      crc_d = crc_q;
      if (update) begin
         crc_d = crc_calc;
      end else if (preset) begin
         crc_d = CRC_PRESET;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q <= CRC_PRESET;
      end else begin
         crc_q <= crc_d;
      end
   end

endmodule

// File: rtl/fm_sector_parser.sv
// FM sector parser: finds ID fields, checks their CRC, captures the data field
// of the selected sector. Define FM_DELETED_DAM_EN to accept deleted data marks.
module fm_sector_parser
   import fm_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   fm_sector_parser_if.slave   bus,
   input  logic [7:0]          target_sector,
   input  logic                match_any,
   output logic [7:0]          id_track,
   output logic [7:0]          id_head,
   output logic [7:0]          id_sector,
   output logic [1:0]          id_size,
   output logic                id_valid,
   output logic                id_crc_err,
   output logic [7:0]          data_out,
   output logic                data_strobe,
   output logic                sector_done,
   output logic                data_crc_err,
   output logic                deleted,
   output logic                no_dam,
   output logic                sector_abort,
   output logic                busy
);

   fm_state_e   state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [7:0]  trk_q, trk_d, hd_q, hd_d, sec_q, sec_d;
   logic [1:0]  sz_q, sz_d;
   logic [7:0]  id_track_q, id_track_d, id_head_q, id_head_d, id_sector_q, id_sector_d;
   logic [1:0]  id_size_q, id_size_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        id_valid_q, id_valid_d, id_crc_err_q, id_crc_err_d;
   logic        data_strobe_q, data_strobe_d, sector_done_q, sector_done_d;
   logic        data_crc_err_q, data_crc_err_d, deleted_q, deleted_d;
   logic        no_dam_q, no_dam_d, sector_abort_q, sector_abort_d;

   logic        step, data_mark, del_mark, start_id, start_data;
   logic        crc_preset, crc_update;
   logic [15:0] crc_calc;
   logic [10:0] len;

   assign step = enable & bus.byte_ready;
   assign len  = sector_len(id_size_q);

`ifdef FM_DELETED_DAM_EN
   assign data_mark = bus.data_am | bus.deleted_am;
   assign del_mark  = bus.deleted_am;
`else
   logic unused_deleted_am;
   assign data_mark         = bus.data_am;
   assign del_mark          = 1'b0;
   assign unused_deleted_am = bus.deleted_am;
`endif

   crc16_ccitt_byte u_crc (
      .clk      (clk),
      .reset    (reset),
      .preset   (crc_preset),
      .update   (crc_update),
      .data     (bus.byte_in),
      .crc_calc (crc_calc)
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      trk_d          = trk_q;
      hd_d           = hd_q;
      sec_d          = sec_q;
      sz_d           = sz_q;
      id_track_d     = id_track_q;
      id_head_d      = id_head_q;
      id_sector_d    = id_sector_q;
      id_size_d      = id_size_q;
      data_out_d     = data_out_q;
      deleted_d      = deleted_q;
      id_valid_d     = 1'b0;
      id_crc_err_d   = 1'b0;
      data_strobe_d  = 1'b0;
      sector_done_d  = 1'b0;
      data_crc_err_d = 1'b0;
      no_dam_d       = 1'b0;
      sector_abort_d = 1'b0;
      crc_preset     = 1'b0;
      crc_update     = 1'b0;
      start_id       = 1'b0;
      start_data     = 1'b0;

      if (step) begin
         unique case (state_q)
            HUNT: begin
               start_id = bus.id_am;
            end
            ID_FIELD: begin
               if (bus.id_am) begin
                  start_id = 1'b1;
               end else if (data_mark) begin
                  state_d = HUNT;
               end else begin
                  crc_update = 1'b1;
                  cnt_d      = cnt_q + 11'd1;
                  case (cnt_q[2:0])
                     3'd0:    trk_d = bus.byte_in;
                     3'd1:    hd_d  = bus.byte_in;
                     3'd2:    sec_d = bus.byte_in;
                     3'd3:    sz_d  = bus.byte_in[1:0];
                     default: ;
                  endcase
                  if (cnt_q == ID_LAST) begin
                     id_track_d   = trk_q;
                     id_head_d    = hd_q;
                     id_sector_d  = sec_q;
                     id_size_d    = sz_q;
                     id_valid_d   = 1'b1;
                     id_crc_err_d = (crc_calc != 16'h0000);
                     if ((crc_calc == 16'h0000) && (match_any || (sec_q == target_sector))) begin
                        state_d = WAIT_DAM;
                        cnt_d   = '0;
                     end else begin
                        state_d = HUNT;
                     end
                  end
               end
            end
            WAIT_DAM: begin
               if (bus.id_am) begin
                  start_id = 1'b1;
               end else if (data_mark) begin
                  start_data = 1'b1;
               end else if (cnt_q == 11'(DAM_WINDOW - 1)) begin
                  no_dam_d = 1'b1;
                  state_d  = HUNT;
               end else begin
                  cnt_d = cnt_q + 11'd1;
               end
            end
            DATA_FIELD: begin
               // A mark inside the field means the field is truncated; drop it.
               if (bus.id_am || data_mark) begin
                  sector_abort_d = 1'b1;
                  start_id       = bus.id_am;
                  state_d        = HUNT;
               end else begin
                  crc_update = 1'b1;
                  cnt_d      = cnt_q + 11'd1;
                  if (cnt_q < len) begin
                     data_out_d    = bus.byte_in;
                     data_strobe_d = 1'b1;
                  end
                  if (cnt_q == len + 11'd1) begin
                     sector_done_d  = 1'b1;
                     data_crc_err_d = (crc_calc != 16'h0000);
                     state_d        = HUNT;
                  end
               end
            end
         endcase
      end

      if (start_id) begin
         state_d    = ID_FIELD;
         cnt_d      = '0;
         crc_preset = 1'b1;
         crc_update = 1'b1;
      end
      if (start_data) begin
         state_d    = DATA_FIELD;
         cnt_d      = '0;
         crc_preset = 1'b1;
         crc_update = 1'b1;
         deleted_d  = del_mark;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= HUNT;
         cnt_q          <= '0;
         trk_q          <= '0;
         hd_q           <= '0;
         sec_q          <= '0;
         sz_q           <= '0;
         id_track_q     <= '0;
         id_head_q      <= '0;
         id_sector_q    <= '0;
         id_size_q      <= '0;
         data_out_q     <= '0;
         deleted_q      <= 1'b0;
         id_valid_q     <= 1'b0;
         id_crc_err_q   <= 1'b0;
         data_strobe_q  <= 1'b0;
         sector_done_q  <= 1'b0;
         data_crc_err_q <= 1'b0;
         no_dam_q       <= 1'b0;
         sector_abort_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         trk_q          <= trk_d;
         hd_q           <= hd_d;
         sec_q          <= sec_d;
         sz_q           <= sz_d;
         id_track_q     <= id_track_d;
         id_head_q      <= id_head_d;
         id_sector_q    <= id_sector_d;
         id_size_q      <= id_size_d;
         data_out_q     <= data_out_d;
         deleted_q      <= deleted_d;
         id_valid_q     <= id_valid_d;
         id_crc_err_q   <= id_crc_err_d;
         data_strobe_q  <= data_strobe_d;
         sector_done_q  <= sector_done_d;
         data_crc_err_q <= data_crc_err_d;
         no_dam_q       <= no_dam_d;
         sector_abort_q <= sector_abort_d;
      end
   end

   assign id_track     = id_track_q;
   assign id_head      = id_head_q;
   assign id_sector    = id_sector_q;
   assign id_size      = id_size_q;
   assign id_valid     = id_valid_q;
   assign id_crc_err   = id_crc_err_q;
   assign data_out     = data_out_q;
   assign data_strobe  = data_strobe_q;
   assign sector_done  = sector_done_q;
   assign data_crc_err = data_crc_err_q;
   assign deleted      = deleted_q;
   assign no_dam       = no_dam_q;
   assign sector_abort = sector_abort_q;
   assign busy         = (state_q != HUNT);

endmodule

// File: tb/tb_fm_sector_parser.sv
// Self-checking bench for fm_sector_parser: vector table of whole sectors, hand
// sequences for window/abort/deleted/reset corners, then randomized sectors.
module tb_fm_sector_parser;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] target_sector;
   logic       match_any;
   logic [7:0] id_track, id_head, id_sector, data_out;
   logic [1:0] id_size;
   logic       id_valid, id_crc_err, data_strobe, sector_done, data_crc_err;
   logic       deleted, no_dam, sector_abort, busy;

   fm_sector_parser_if bus ();

   always #5 clk = ~clk;

   fm_sector_parser dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .bus           (bus),
      .target_sector (target_sector),
      .match_any     (match_any),
      .id_track      (id_track),
      .id_head       (id_head),
      .id_sector     (id_sector),
      .id_size       (id_size),
      .id_valid      (id_valid),
      .id_crc_err    (id_crc_err),
      .data_out      (data_out),
      .data_strobe   (data_strobe),
      .sector_done   (sector_done),
      .data_crc_err  (data_crc_err),
      .deleted       (deleted),
      .no_dam        (no_dam),
      .sector_abort  (sector_abort),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Event log: every pulse seen once per cycle, away from the active edge.
   logic [7:0] strobe_log[$];
   int n_idv = 0, n_ider = 0, n_done = 0, n_derr = 0, n_nodam = 0, n_abort = 0;
   logic [7:0] last_trk, last_hd, last_sec;
   logic [1:0] last_sz;

   always @(negedge clk) begin
      if (!reset) begin
         if (data_strobe) strobe_log.push_back(data_out);
         if (id_valid) begin
            n_idv++;
            last_trk = id_track;
            last_hd  = id_head;
            last_sec = id_sector;
            last_sz  = id_size;
         end
         if (id_crc_err)   n_ider++;
         if (sector_done)  n_done++;
         if (data_crc_err) n_derr++;
         if (no_dam)       n_nodam++;
         if (sector_abort) n_abort++;
      end
   end

   bit rand_mode = 1'b0;
   logic [7:0] pay_q[$];

   function automatic logic [15:0] crc_of(input logic [7:0] msg[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (msg[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ msg[i][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   task automatic idle(input int n);
      bus.byte_ready = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One byte consumed per call; in random mode, ignored junk and idle cycles are mixed in.
   task automatic put(input logic [7:0] b, input logic ida, input logic da, input logic dda);
      if (rand_mode) begin
         if ($urandom_range(0, 3) == 0) begin
            enable         = 1'b0;
            bus.byte_ready = 1'b1;
            bus.byte_in    = 8'($urandom);
            bus.id_am      = 1'($urandom_range(0, 1));
            bus.data_am    = 1'($urandom_range(0, 1));
            bus.deleted_am = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            enable = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.byte_ready = 1'b0;
            bus.id_am      = 1'b0;
            bus.data_am    = 1'b0;
            bus.deleted_am = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      bus.byte_in    = b;
      bus.byte_ready = 1'b1;
      bus.id_am      = ida;
      bus.data_am    = da;
      bus.deleted_am = dda;
      @(posedge clk);
      #1;
      bus.byte_ready = 1'b0;
      bus.id_am      = 1'b0;
      bus.data_am    = 1'b0;
      bus.deleted_am = 1'b0;
   endtask

   task automatic send_id(input logic [7:0] trk, input logic [7:0] hd, input logic [7:0] sec,
                          input logic [7:0] szb, input logic bad);
      logic [7:0]  m[$];
      logic [15:0] c;
      m.push_back(8'hFE);
      m.push_back(trk);
      m.push_back(hd);
      m.push_back(sec);
      m.push_back(szb);
      c = crc_of(m);
      put(8'hFE, 1'b1, 1'b0, 1'b0);
      put(trk, 1'b0, 1'b0, 1'b0);
      put(hd, 1'b0, 1'b0, 1'b0);
      put(sec, 1'b0, 1'b0, 1'b0);
      put(szb, 1'b0, 1'b0, 1'b0);
      put(c[15:8], 1'b0, 1'b0, 1'b0);
      put(c[7:0] ^ (bad ? 8'hFF : 8'h00), 1'b0, 1'b0, 1'b0);
      chk("id_valid_lat", {31'd0, id_valid}, 32'd1);
      chk("id_crc_err_lat", {31'd0, id_crc_err}, {31'd0, bad});
   endtask

   task automatic fill_payload(input int len);
      pay_q.delete();
      for (int k = 0; k < len; k++) pay_q.push_back(rand_mode ? 8'($urandom) : 8'(k));
   endtask

   // kind 0 = FB data mark, 1 = F8 deleted mark; nsend < payload size leaves the field unfinished.
   task automatic send_data(input bit kind, input int nsend, input logic bad, input logic exp_cap);
      logic [7:0]  m[$];
      logic [15:0] c;
      logic [7:0]  mark;
      mark = kind ? 8'hF8 : 8'hFB;
      m.push_back(mark);
      foreach (pay_q[k]) m.push_back(pay_q[k]);
      c = crc_of(m);
      put(mark, 1'b0, !kind, kind);
      for (int k = 0; k < nsend; k++) begin
         put(pay_q[k], 1'b0, 1'b0, 1'b0);
         if (k == 0) begin
            chk("strobe_lat", {31'd0, data_strobe}, {31'd0, exp_cap});
            if (exp_cap) chk("data_out_lat", {24'd0, data_out}, {24'd0, pay_q[0]});
         end
      end
      if (nsend == pay_q.size()) begin
         put(c[15:8], 1'b0, 1'b0, 1'b0);
         chk("crc_not_strobed", {31'd0, data_strobe}, 32'd0);
         put(c[7:0] ^ (bad ? 8'hFF : 8'h00), 1'b0, 1'b0, 1'b0);
         chk("done_lat", {31'd0, sector_done}, {31'd0, exp_cap});
         chk("derr_lat", {31'd0, data_crc_err}, {31'd0, exp_cap & bad});
      end
   endtask

   task automatic chk_strobes(input string p, input int base, input int n);
      int bad;
      bad = 0;
      chk({p, "_strobe_cnt"}, strobe_log.size() - base, n);
      for (int k = 0; k < n; k++) begin
         if ((base + k) < strobe_log.size() && strobe_log[base + k] !== pay_q[k]) bad++;
      end
      chk({p, "_strobe_data"}, bad, 0);
   endtask

   task automatic run_frame(input string p, input logic [7:0] trk, input logic [7:0] hd,
                            input logic [7:0] sec, input logic [7:0] szb, input logic [7:0] tgt,
                            input logic any, input int gap, input logic bad_id, input logic bad_dat,
                            input int exp_strobes, input logic exp_done, input logic exp_derr);
      int bs, bi, be, bd, bx, bn, ba;
      target_sector = tgt;
      match_any     = any;
      bs = strobe_log.size();
      bi = n_idv; be = n_ider; bd = n_done; bx = n_derr; bn = n_nodam; ba = n_abort;
      fill_payload(128 << szb[1:0]);
      send_id(trk, hd, sec, szb, bad_id);
      for (int g = 0; g < gap; g++) put(8'h00, 1'b0, 1'b0, 1'b0);
      send_data(1'b0, pay_q.size(), bad_dat, exp_done);
      idle(2);
      chk({p, "_idv"}, n_idv - bi, 1);
      chk({p, "_id_fields"}, {6'd0, last_trk, last_hd, last_sec, last_sz}, {6'd0, trk, hd, sec, szb[1:0]});
      chk({p, "_id_crc_err"}, n_ider - be, {31'd0, bad_id});
      chk_strobes(p, bs, exp_strobes);
      chk({p, "_done"}, n_done - bd, {31'd0, exp_done});
      chk({p, "_derr"}, n_derr - bx, {31'd0, exp_derr});
      chk({p, "_nodam_abort"}, (n_nodam - bn) + (n_abort - ba), 0);
      chk({p, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [7:0] trk, hd, sec, szb, tgt;
      logic       any;
      int         gap;
      logic       bad_id, bad_dat;
      int         exp_strobes;
      logic       exp_done, exp_derr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int bs, bn, ba, bd, bi;
      logic [7:0] trk, hd, sec, szb, tgt;
      logic any, bid, bdat, cap;
      int len, g;

      //            trk    hd     sec    szb    tgt    any gap bid bdat strobes done derr
      tbl[0] = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 6,  1'b0, 1'b0, 128,  1'b1, 1'b0};
      tbl[1] = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 6,  1'b0, 1'b1, 128,  1'b1, 1'b1};
      tbl[2] = '{8'h05, 8'h00, 8'h04, 8'h00, 8'h03, 1'b0, 6,  1'b0, 1'b0, 0,    1'b0, 1'b0};
      tbl[3] = '{8'h05, 8'h00, 8'h04, 8'hFE, 8'h03, 1'b1, 29, 1'b0, 1'b0, 512,  1'b1, 1'b0};
      tbl[4] = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 6,  1'b1, 1'b0, 0,    1'b0, 1'b0};
      tbl[5] = '{8'h4F, 8'h01, 8'h7A, 8'h03, 8'h7A, 1'b0, 0,  1'b0, 1'b1, 1024, 1'b1, 1'b1};
      tbl[6] = '{8'h00, 8'h01, 8'h01, 8'h55, 8'h02, 1'b1, 11, 1'b0, 1'b0, 256,  1'b1, 1'b0};

      reset          = 1'b1;
      enable         = 1'b1;
      target_sector  = 8'h00;
      match_any      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_ready = 1'b0;
      bus.id_am      = 1'b0;
      bus.data_am    = 1'b0;
      bus.deleted_am = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_id_regs", {id_track, id_head, id_sector, 6'd0, id_size}, 32'd0);
      chk("reset_data_out", {24'd0, data_out}, 32'd0);
      chk("reset_flags", {23'd0, id_valid, id_crc_err, data_strobe, sector_done, data_crc_err,
                          deleted, no_dam, sector_abort, busy}, 32'd0);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), tbl[i].trk, tbl[i].hd, tbl[i].sec, tbl[i].szb,
                   tbl[i].tgt, tbl[i].any, tbl[i].gap, tbl[i].bad_id, tbl[i].bad_dat,
                   tbl[i].exp_strobes, tbl[i].exp_done, tbl[i].exp_derr);
         $display("vec%0d: sector %0h target %0h size %0d strobes %0d done %0d derr %0d", i,
                  tbl[i].sec, tbl[i].tgt, tbl[i].szb[1:0], tbl[i].exp_strobes, tbl[i].exp_done, tbl[i].exp_derr);
      end

      // Data-mark window runs out on the 30th byte.
      target_sector = 8'h03;
      match_any     = 1'b0;
      bn = n_nodam;
      send_id(8'h05, 8'h00, 8'h03, 8'h00, 1'b0);
      for (int k = 1; k <= 30; k++) begin
         put(8'hFF, 1'b0, 1'b0, 1'b0);
         if (k == 29) chk("nodam_before", {30'd0, no_dam, busy}, 32'd1);
         if (k == 30) chk("nodam_at_30", {30'd0, no_dam, busy}, 32'd2);
      end
      idle(2);
      chk("nodam_count", n_nodam - bn, 1);
      $display("no_dam: window expiry after 30 bytes");

      // Abort a 256-byte field after 50 bytes with a new ID mark.
      target_sector = 8'h09;
      bs = strobe_log.size(); ba = n_abort; bd = n_done; bi = n_idv;
      send_id(8'h07, 8'h01, 8'h09, 8'h01, 1'b0);
      fill_payload(256);
      send_data(1'b0, 50, 1'b0, 1'b1);
      send_id(8'h08, 8'h00, 8'h22, 8'h00, 1'b0);
      idle(2);
      chk("abort_count", n_abort - ba, 1);
      chk_strobes("abort", bs, 50);
      chk("abort_no_done", n_done - bd, 0);
      chk("abort_new_id", {n_idv - bi, 8'd0, last_trk, last_sec}, {16'd2, 8'd0, 8'h08, 8'h22});
      chk("abort_busy", {31'd0, busy}, 32'd0);
      $display("abort: 50 strobes then new ID track %0h sector %0h", last_trk, last_sec);

      // Deleted data mark.
      target_sector = 8'h03;
      bs = strobe_log.size(); bn = n_nodam; bd = n_done;
      send_id(8'h05, 8'h00, 8'h03, 8'h00, 1'b0);
      fill_payload(128);
`ifdef FM_DELETED_DAM_EN
      send_data(1'b1, 128, 1'b0, 1'b1);
      idle(2);
      chk("deleted_flag", {31'd0, deleted}, 32'd1);
      chk_strobes("deleted", bs, 128);
      chk("deleted_done", {n_done - bd, n_nodam - bn}, {32'd1, 32'd0});
`else
      send_data(1'b1, 128, 1'b0, 1'b0);
      idle(2);
      chk("deleted_flag", {31'd0, deleted}, 32'd0);
      chk_strobes("deleted", bs, 0);
      chk("deleted_done", {n_done - bd, n_nodam - bn}, {32'd0, 32'd1});
`endif
      run_frame("after_del", 8'h05, 8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 3, 1'b0, 1'b0, 128, 1'b1, 1'b0);
      chk("deleted_cleared", {31'd0, deleted}, 32'd0);
      $display("deleted: mark F8 handled, flag now %0d", deleted);

      // Reset in the middle of a data field.
      send_id(8'h05, 8'h00, 8'h03, 8'h00, 1'b0);
      fill_payload(128);
      send_data(1'b0, 20, 1'b0, 1'b1);
      bs = strobe_log.size(); bn = n_nodam; ba = n_abort; bd = n_done;
      reset = 1'b1;
      #1;
      chk("midreset_outputs", {data_out, id_track, id_sector, 5'd0, busy, data_strobe, deleted},
          32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 40; k++) put(8'h11, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("midreset_no_pulses", (n_nodam - bn) + (n_abort - ba) + (n_done - bd), 0);
      chk("midreset_no_strobes", strobe_log.size() - bs, 0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      $display("midreset: field abandoned silently");

      // Randomized sectors with enable gaps and junk cycles.
      rand_mode = 1'b1;
      for (int f = 0; f < 12; f++) begin
         trk  = 8'($urandom);
         hd   = 8'($urandom);
         szb  = 8'($urandom);
         tgt  = 8'($urandom);
         sec  = ($urandom_range(0, 1) == 1) ? tgt : 8'($urandom);
         any  = ($urandom_range(0, 9) < 3);
         bid  = ($urandom_range(0, 9) < 2);
         bdat = ($urandom_range(0, 9) < 2);
         g    = $urandom_range(0, 29);
         cap  = !bid && (any || (sec == tgt));
         len  = 128 << szb[1:0];
         run_frame($sformatf("rnd%0d", f), trk, hd, sec, szb, tgt, any, g, bid, bdat,
                   cap ? len : 0, cap, cap && bdat);
         $display("rnd%0d: sector %0h target %0h any %0d size %0d bad_id %0d bad_data %0d captured %0d",
                  f, sec, tgt, any, szb[1:0], bid, bdat, cap);
      end
      rand_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
